counter_seq_ctrl: RTL

//   Sequencer directly upstream of the loadable up-counter. Drives the counter's load strobe (st) and load value (X).

---
 rtl/counter_seq_ctrl_pkg.sv | 10 +
 rtl/counter_seq_ctrl_eq_cmp.sv | 12 +
 rtl/counter_seq_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/counter_seq_ctrl_pkg.sv
// Shared constants for the counter sequencer: state encoding and state width.
package counter_seq_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/counter_seq_ctrl_eq_cmp.sv
// Equality comparator used for the terminal-count match.
module eq_cmp #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  output logic                 eq
);

  assign eq = (a == b);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a reset-less loadable up-counter: parks it at base, runs it to limit, reports tick/done.
// COUNTER_SEQ_AUTO_RELOAD_EN selects periodic reload instead of one-shot completion.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [BUS_WIDTH-1:0] base,
  input  logic [BUS_WIDTH-1:0] limit,
  input  logic [BUS_WIDTH-1:0] cnt,
  output logic                 st,
  output logic [BUS_WIDTH-1:0] X,
  output logic                 busy,
  output logic                 tick,
  output logic                 done
);

  logic [STATE_W-1:0]   state_q;
  logic [STATE_W-1:0]   state_d;
  logic [BUS_WIDTH-1:0] base_q;
  logic [BUS_WIDTH-1:0] limit_q;
  logic                 match;
  logic                 capture;
  logic                 tick_d;

  eq_cmp #(.BUS_WIDTH(BUS_WIDTH)) u_match (
    .a  (cnt),
    .b  (limit_q),
    .eq (match)
  );

  // Next state, counter load control and capture strobe
  always_comb begin
    state_d = state_q;
    st      = 1'b1;
    X       = base_q;
    capture = 1'b0;
    tick_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        X = base;
        if (start && !stop) begin
          state_d = ST_RUN;
          capture = 1'b1;
        end
      end
      ST_RUN: begin
        st = match;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (match) begin
          tick_d = 1'b1;
`ifndef COUNTER_SEQ_AUTO_RELOAD_EN
          state_d = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          capture = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured operands and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      limit_q <= '0;
      busy    <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        base_q  <= base;
        limit_q <= limit;
      end
      busy <= (state_d == ST_RUN);
      tick <= tick_d;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
      done <= 1'b0;
`else
      done <= (state_d == ST_DONE);
`endif
    end
  end

endmodule
